// File: rtl/intt_pkg.sv
// Shared constants, state encoding and butterfly address helper for the
// inverse-NTT schedule controllers.
package intt_pkg;

  localparam int N            = 256;
  localparam int LAYERS       = 7;
  localparam int ADDR_W       = 8;
  localparam int ZADDR_W      = 7;
  localparam int Q            = 3329;
  localparam int BF_PER_LAYER = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  a;
    logic [ADDR_W-1:0]  b;
    logic [ZADDR_W-1:0] k;
  } bf_addr_t;

  // Gentleman-Sande indexing: butterfly c of layer l touches j and j+len,
  // with zetas consumed from the top of the table downwards.
  function automatic bf_addr_t bf_addr(input logic [2:0] l, input logic [6:0] c);
    bf_addr_t   r;
    logic [7:0] len;
    logic [7:0] g;
    logic [7:0] off;
    logic [3:0] sh;
    len = 8'd2 << l;
    g   = {1'b0, c} >> (l + 3'd1);
    off = {1'b0, c} & (len - 8'd1);
    sh  = {1'b0, l} + 4'd2;
    r.a = (g << sh) + off;
    r.b = r.a + len;
    r.k = 7'((8'd128 >> l) - 8'd1 - g);
    return r;
  endfunction

endpackage

// File: rtl/intt_wb_delay.sv
// Fixed-depth delay line carrying {valid, a, b} from issue to write-back.
module intt_wb_delay #(
  parameter int DEPTH = 25,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Clearing every stage drops in-flight writes of an aborted transform.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/intt_ctrl.sv
// Inverse-NTT schedule controller: issues one butterfly per cycle and
// replays its A/B addresses as write-back addresses after the butterfly latency.
module intt_ctrl
  import intt_pkg::*;
#(
  parameter int BU_LAT = 24,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr_a,
  output logic [ADDR_W-1:0]  rd_addr_b,
  output logic [ZADDR_W-1:0] zeta_addr,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr_a,
  output logic [ADDR_W-1:0]  wr_addr_b,
  output logic [2:0]         layer
);

  localparam int L  = RD_LAT + BU_LAT;
  localparam int DW = (L > 1) ? $clog2(L) : 1;
  localparam int WBW = 1 + 2 * ADDR_W;

  state_t             state_q, state_d;
  logic [2:0]         layer_q, layer_d;
  logic [6:0]         c_q, c_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  rd_a_q, rd_a_d;
  logic [ADDR_W-1:0]  rd_b_q, rd_b_d;
  logic [ZADDR_W-1:0] zeta_q, zeta_d;
  bf_addr_t           nxt;
  logic [WBW-1:0]     wb_out;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    c_d     = c_q;
    dcnt_d  = dcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    zeta_d  = zeta_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          layer_d = 3'd0;
          c_d     = 7'd0;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (c_q == 7'd127) begin
          state_d = S_DRAIN;
          c_d     = 7'd0;
          dcnt_d  = '0;
        end else begin
          c_d     = c_q + 7'd1;
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(L - 1)) begin
          if (layer_q == 3'(LAYERS - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            layer_d = layer_q + 3'd1;
            c_d     = 7'd0;
            rd_en_d = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Addresses are computed for the butterfly about to appear on the outputs.
    nxt = bf_addr(layer_d, c_d);
    if (rd_en_d) begin
      rd_a_d = nxt.a;
      rd_b_d = nxt.b;
      zeta_d = nxt.k;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= 3'd0;
      c_q     <= 7'd0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      zeta_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      c_q     <= c_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      zeta_q  <= zeta_d;
    end
  end

  // A butterfly visible on the read port in cycle t writes back in cycle t+L.
  intt_wb_delay #(
    .DEPTH (L),
    .WIDTH (WBW)
  ) u_wb_delay (
    .clk  (clk),
    .clr  (rst),
    .din  ({rd_en_q, rd_a_q, rd_b_q}),
    .dout (wb_out)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign zeta_addr = zeta_q;
  assign layer     = layer_q;
  assign wr_en     = wb_out[WBW-1];
  assign wr_addr_a = wb_out[2*ADDR_W-1:ADDR_W];
  assign wr_addr_b = wb_out[ADDR_W-1:0];

endmodule

// File: tb/tb_intt_ctrl.sv
// Randomized bench for intt_ctrl against a cycle-position reference model
// built from the Gentleman-Sande loop nest.
module tb_intt_ctrl;

  localparam int BU_LAT = 24;
  localparam int RD_LAT = 1;
  localparam int L      = BU_LAT + RD_LAT;
  localparam int P      = 128 + L;
  localparam int TOTAL  = 7 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] zeta_addr;
  logic [2:0] layer;

  intt_ctrl #(.BU_LAT(BU_LAT), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .zeta_addr (zeta_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .layer     (layer)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference tables: butterfly order of the textbook INTT loop nest.
  int ta [7][128];
  int tb [7][128];
  int tk [7][128];

  // Model state: whether a transform is in flight and cycles since acceptance.
  bit active    = 1'b0;
  int rel       = 0;
  bit after_rst = 1'b0;
  int done_obs  = 0;
  int done_exp  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic build_tables();
    int k;
    k = 127;
    for (int lay = 0; lay < 7; lay++) begin
      int len;
      int idx;
      len = 2 << lay;
      idx = 0;
      for (int st = 0; st < 256; st = st + 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          ta[lay][idx] = j;
          tb[lay][idx] = j + len;
          tk[lay][idx] = k;
          idx++;
        end
        k--;
      end
    end
  endtask

  task automatic step(input bit r, input bit s);
    bit e_rd, e_wr, e_done, in_x;
    int pos, lay, w, wl, wc;
    rst   = r;
    start = s;
    @(posedge clk);
    cyc++;
    if (r) begin
      active    = 1'b0;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (active) begin
        rel++;
        if (rel == TOTAL + 2) active = 1'b0;
      end else if (s) begin
        active = 1'b1;
        rel    = 1;
      end
    end
    #1;
    in_x   = active && (rel <= TOTAL);
    pos    = in_x ? (rel - 1) % P : 0;
    lay    = in_x ? (rel - 1) / P : 0;
    e_rd   = in_x && (pos < 128);
    e_done = active && (rel == TOTAL + 1);
    w      = rel - L;
    e_wr   = active && (w >= 1) && (w <= TOTAL) && (((w - 1) % P) < 128);
    wl     = e_wr ? (w - 1) / P : 0;
    wc     = e_wr ? (w - 1) % P : 0;
    if (done) done_obs++;
    if (e_done) done_exp++;

    chk("busy", 32'(busy), 32'(active));
    chk("done", 32'(done), 32'(e_done));
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    if (in_x) chk("layer", 32'(layer), 32'(lay));
    if (e_rd) begin
      chk("rd_addr_a", 32'(rd_addr_a), 32'(ta[lay][pos]));
      chk("rd_addr_b", 32'(rd_addr_b), 32'(tb[lay][pos]));
      chk("zeta_addr", 32'(zeta_addr), 32'(tk[lay][pos]));
    end
    if (e_wr) begin
      chk("wr_addr_a", 32'(wr_addr_a), 32'(ta[wl][wc]));
      chk("wr_addr_b", 32'(wr_addr_b), 32'(tb[wl][wc]));
    end
    if (after_rst) begin
      chk("rst_addrs", {rd_addr_a, rd_addr_b, zeta_addr, 1'b0, layer}, 32'd0);
      chk("rst_wr_addrs", {16'd0, wr_addr_a, wr_addr_b}, 32'd0);
    end
    // Known schedule points for the default latency.
    if (active) begin
      case (rel)
        1:    chk("l0_c0",   {9'd0, rd_addr_a, rd_addr_b, zeta_addr}, {9'd0, 8'd0,   8'd2,   7'd127});
        2:    chk("l0_c1",   {9'd0, rd_addr_a, rd_addr_b, zeta_addr}, {9'd0, 8'd1,   8'd3,   7'd127});
        3:    chk("l0_c2",   {9'd0, rd_addr_a, rd_addr_b, zeta_addr}, {9'd0, 8'd4,   8'd6,   7'd126});
        26:   chk("wr_first", {15'd0, wr_en, wr_addr_a, wr_addr_b}, {15'd0, 1'b1, 8'd0, 8'd2});
        128:  chk("l0_c127", {9'd0, rd_addr_a, rd_addr_b, zeta_addr}, {9'd0, 8'd253, 8'd255, 7'd64});
        154:  chk("l1_c0",   {9'd0, rd_addr_a, rd_addr_b, zeta_addr}, {9'd0, 8'd0,   8'd4,   7'd63});
        158:  chk("l1_c4",   {9'd0, rd_addr_a, rd_addr_b, zeta_addr}, {9'd0, 8'd8,   8'd12,  7'd62});
        924:  chk("l6_c5",   {9'd0, rd_addr_a, rd_addr_b, zeta_addr}, {9'd0, 8'd5,   8'd133, 7'd1});
        1072: chk("done_cyc", 32'(done), 32'd1);
        default: ;
      endcase
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (active && n < 1200) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("idle_bound", 32'(active), 32'd0);
  endtask

  initial begin
    int held_base_obs, held_base_exp;
    build_tables();

    // Reset, then one transform with ignored start pulses while busy.
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 1100; i++) step(1'b0, ($urandom % 16) == 0);
    wait_idle();

    // Abort mid-transform, confirm no stray writes, then restart cleanly.
    step(1'b0, 1'b1);
    for (int i = 0; i < 298; i++) step(1'b0, ($urandom % 8) == 0);
    step(1'b1, 1'b0);
    for (int i = 0; i < L + 5; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 1100; i++) step(1'b0, 1'b0);
    wait_idle();

    // Start held high: re-accepted every time the controller returns to idle.
    held_base_obs = done_obs;
    held_base_exp = done_exp;
    for (int i = 0; i < 2200; i++) step(1'b0, 1'b1);
    chk("held_dones", 32'(done_obs - held_base_obs), 32'(done_exp - held_base_exp));
    chk("held_dones_n", 32'(done_obs - held_base_obs), 32'd2);

    // Free-running random start and occasional reset.
    for (int i = 0; i < 3000; i++) step(($urandom % 900) == 0, ($urandom % 40) == 0);

    chk("done_total", 32'(done_obs), 32'(done_exp));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
